// File: rtl/mc_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main controller.
package mc_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_ALU_WB     = 4'd4,
    S_MEM_ADDR   = 4'd5,
    S_MEM_REQ    = 4'd6,
    S_MEM_WAIT   = 4'd7,
    S_MEM_WB     = 4'd8,
    S_BRANCH     = 4'd9,
    S_JUMP       = 4'd10,
    S_TRAP       = 4'd11
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_ALU  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] SRC_A_RS1    = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_ZERO   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_CMP   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_control_unit_if.sv
// Shared instruction/data memory port handshake between controller and memory.
interface mc_control_unit_if;
  logic mem_req_o;
  logic mem_we_o;
  logic iord_o;
  logic mem_gnt_i;
  logic mem_rvalid_i;

  modport master (output mem_req_o, mem_we_o, iord_o, input mem_gnt_i, mem_rvalid_i);
  modport slave  (input mem_req_o, mem_we_o, iord_o, output mem_gnt_i, mem_rvalid_i);
endinterface

// File: rtl/mc_control_unit_timeout.sv
// Saturating wait-state counter; expired_o flags the last permitted cycle.
module mc_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_ni, clear_i, enable_i};
    assign expired_o     = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (enable_i && (cnt_q != LIMIT)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign expired_o = enable_i && (cnt_q == LIMIT);
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and traps on illegal opcodes and bus timeouts.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ALU_OP_W       = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         instr_i,
  mc_control_unit_if.master   mem,
  input  logic                branch_taken_i,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_src_o,
  output logic                reg_write_o,
  output logic [1:0]          wb_sel_o,
  output logic [1:0]          alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                trap_o,
  output logic [1:0]          trap_cause_o,
  output logic [3:0]          state_o
);

  state_e     state_d, state_q;
  logic [1:0] trap_cause_d, trap_cause_q;
  logic [6:0] opcode;
  logic       wait_state, expired;
  logic       mem_req, mem_we, iord;
  logic       unused_instr;

  assign opcode       = instr_i[6:0];
  assign unused_instr = ^instr_i[31:7];
  assign wait_state   = (state_q == S_FETCH)    || (state_q == S_FETCH_WAIT) ||
                        (state_q == S_MEM_REQ)  || (state_q == S_MEM_WAIT);

  mc_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_d != state_q),
    .enable_i (wait_state),
    .expired_o(expired)
  );

  // Awaited handshake events are tested before expiry so a coincident event wins.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem.mem_gnt_i)  state_d = S_FETCH_WAIT;
        else if (expired) begin state_d = S_TRAP; trap_cause_d = CAUSE_TIMEOUT; end
      end
      S_FETCH_WAIT: begin
        if (mem.mem_rvalid_i) state_d = S_DECODE;
        else if (expired) begin state_d = S_TRAP; trap_cause_d = CAUSE_TIMEOUT; end
      end
      S_DECODE: begin
        unique case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: state_d = S_EXEC;
          OPC_LOAD, OPC_STORE:                    state_d = S_MEM_ADDR;
          OPC_BRANCH:                             state_d = S_BRANCH;
          OPC_JAL, OPC_JALR:                      state_d = S_JUMP;
          OPC_FENCE:                              state_d = S_FETCH;
          default: begin state_d = S_TRAP; trap_cause_d = CAUSE_ILLEGAL; end
        endcase
      end
      S_EXEC:     state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = S_MEM_REQ;
      S_MEM_REQ: begin
        if (mem.mem_gnt_i) state_d = (opcode == OPC_STORE) ? S_FETCH : S_MEM_WAIT;
        else if (expired) begin state_d = S_TRAP; trap_cause_d = CAUSE_TIMEOUT; end
      end
      S_MEM_WAIT: begin
        if (mem.mem_rvalid_i) state_d = S_MEM_WB;
        else if (expired) begin state_d = S_TRAP; trap_cause_d = CAUSE_TIMEOUT; end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_FETCH;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // Decode is gated by rst_ni so every output reads zero while reset is held.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = PC_SRC_PC4;
    reg_write_o = 1'b0;
    wb_sel_o    = WB_ALU;
    alu_src_a_o = SRC_A_RS1;
    alu_src_b_o = SRC_B_RS2;
    alu_op_o    = ALU_OP_W'(ALU_OP_ADD);
    trap_o      = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        S_FETCH: mem_req = 1'b1;
        S_FETCH_WAIT: begin
          ir_write_o = mem.mem_rvalid_i;
          pc_write_o = mem.mem_rvalid_i;
        end
        S_DECODE: begin
          alu_src_a_o = SRC_A_OLD_PC;
          alu_src_b_o = SRC_B_IMM;
        end
        S_EXEC: begin
          unique case (opcode)
            OPC_OP:     alu_op_o = ALU_OP_W'(ALU_OP_RTYPE);
            OPC_OP_IMM: begin alu_src_b_o = SRC_B_IMM; alu_op_o = ALU_OP_W'(ALU_OP_ITYPE); end
            OPC_LUI:    begin alu_src_a_o = SRC_A_ZERO;   alu_src_b_o = SRC_B_IMM; end
            OPC_AUIPC:  begin alu_src_a_o = SRC_A_OLD_PC; alu_src_b_o = SRC_B_IMM; end
            default: ;
          endcase
        end
        S_ALU_WB:   reg_write_o = 1'b1;
        S_MEM_ADDR: alu_src_b_o = SRC_B_IMM;
        S_MEM_REQ: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (opcode == OPC_STORE);
        end
        S_MEM_WB: begin
          reg_write_o = 1'b1;
          wb_sel_o    = WB_MEM;
        end
        S_BRANCH: begin
          alu_op_o   = ALU_OP_W'(ALU_OP_CMP);
          pc_write_o = branch_taken_i;
          pc_src_o   = PC_SRC_ALU;
        end
        S_JUMP: begin
          reg_write_o = 1'b1;
          wb_sel_o    = WB_PC4;
          pc_write_o  = 1'b1;
          pc_src_o    = PC_SRC_ALU;
          if (opcode == OPC_JALR) alu_src_b_o = SRC_B_IMM;
        end
        S_TRAP: begin
          trap_o     = 1'b1;
          pc_write_o = 1'b1;
          pc_src_o   = PC_SRC_TRAP;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req_o = mem_req;
  assign mem.mem_we_o  = mem_we;
  assign mem.iord_o    = iord;
  assign trap_cause_o  = trap_cause_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: one instance with a short timeout, one with it disabled.
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        br;

  logic       ir_write, pc_write, reg_write, trap;
  logic [1:0] pc_src, wb_sel, src_a, src_b, alu_op, cause;
  logic [3:0] state;

  logic       ir_write0, pc_write0, reg_write0, trap0;
  logic [1:0] pc_src0, wb_sel0, src_a0, src_b0, alu_op0, cause0;
  logic [3:0] state0;

  int vectors = 0;
  int miscompares = 0;

  mc_control_unit_if bus ();
  mc_control_unit_if bus0 ();

  mc_control_unit #(.TIMEOUT_CYCLES(4), .ALU_OP_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .mem(bus), .branch_taken_i(br),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .reg_write_o(reg_write), .wb_sel_o(wb_sel), .alu_src_a_o(src_a),
    .alu_src_b_o(src_b), .alu_op_o(alu_op), .trap_o(trap),
    .trap_cause_o(cause), .state_o(state)
  );

  mc_control_unit #(.TIMEOUT_CYCLES(0), .ALU_OP_W(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .mem(bus0), .branch_taken_i(br),
    .ir_write_o(ir_write0), .pc_write_o(pc_write0), .pc_src_o(pc_src0),
    .reg_write_o(reg_write0), .wb_sel_o(wb_sel0), .alu_src_a_o(src_a0),
    .alu_src_b_o(src_b0), .alu_op_o(alu_op0), .trap_o(trap0),
    .trap_cause_o(cause0), .state_o(state0)
  );

  logic [22:0] outs, outs0;
  assign outs  = {bus.mem_req_o, bus.mem_we_o, bus.iord_o, ir_write, pc_write, pc_src,
                  reg_write, wb_sel, src_a, src_b, alu_op, trap, cause, state};
  assign outs0 = {bus0.mem_req_o, bus0.mem_we_o, bus0.iord_o, ir_write0, pc_write0, pc_src0,
                  reg_write0, wb_sel0, src_a0, src_b0, alu_op0, trap0, cause0, state0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch starting in FETCH; returns 2 ns into the DECODE cycle.
  task automatic do_fetch(input logic [31:0] ins);
    instr = ins;
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("fetch_state", 32'(state), 32'(S_FETCH));
    chk("fetch_req_iord", {bus.mem_req_o, bus.iord_o}, 32'b10);
    nxt();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    #1;
    chk("fwait_state", 32'(state), 32'(S_FETCH_WAIT));
    chk("fwait_pulses", {ir_write, pc_write, pc_src}, 32'b1100);
    nxt();
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("decode_state", 32'(state), 32'(S_DECODE));
    chk("decode_alu", {src_a, src_b, alu_op, ir_write, pc_write}, 32'b01010000);
  endtask

  task automatic do_alu(input string tag, input logic [31:0] ins,
                        input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] eop);
    do_fetch(ins);
    nxt();
    chk({tag, "_exec_state"}, 32'(state), 32'(S_EXEC));
    chk({tag, "_exec_alu"}, {src_a, src_b, alu_op, reg_write}, {ea, eb, eop, 1'b0});
    nxt();
    chk({tag, "_wb"}, {state, reg_write, wb_sel}, {4'(S_ALU_WB), 1'b1, 2'b00});
    nxt();
    chk({tag, "_done"}, 32'(state), 32'(S_FETCH));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    instr = '0;
    br    = 1'b0;
    bus.mem_gnt_i     = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus0.mem_gnt_i    = 1'b0;
    bus0.mem_rvalid_i = 1'b0;
    #2;
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_outs0", 32'(outs0), 32'd0);
    #10;
    rst_n = 1'b1;

    do_alu("addi",  32'h00500093, 2'b00, 2'b01, 2'b11);
    do_alu("add",   32'h002081b3, 2'b00, 2'b00, 2'b10);
    do_alu("lui",   32'h000010b7, 2'b10, 2'b01, 2'b00);
    do_alu("auipc", 32'h00001097, 2'b01, 2'b01, 2'b00);

    // LW: gnt after 3 idle request cycles (coincides with timeout limit), rvalid after 2
    do_fetch(32'h00002083);
    nxt();
    chk("lw_addr", {state, src_a, src_b, alu_op}, {4'(S_MEM_ADDR), 6'b000100});
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("lw_req_hold", {state, bus.mem_req_o, bus.iord_o, bus.mem_we_o},
          {4'(S_MEM_REQ), 3'b110});
    end
    nxt();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("lw_req_gnt", {state, bus.mem_req_o, bus.mem_we_o}, {4'(S_MEM_REQ), 2'b10});
    nxt();
    bus.mem_gnt_i = 1'b0;
    #1;
    chk("lw_wait1", {state, bus.mem_req_o}, {4'(S_MEM_WAIT), 1'b0});
    nxt();
    chk("lw_wait2", 32'(state), 32'(S_MEM_WAIT));
    nxt();
    bus.mem_rvalid_i = 1'b1;
    #1;
    chk("lw_wait3", {state, reg_write}, {4'(S_MEM_WAIT), 1'b0});
    nxt();
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("lw_wb", {state, reg_write, wb_sel}, {4'(S_MEM_WB), 1'b1, 2'b01});
    nxt();
    chk("lw_done", 32'(state), 32'(S_FETCH));

    // SW zero-wait
    do_fetch(32'h00102023);
    nxt();
    nxt();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("sw_req", {state, bus.mem_req_o, bus.iord_o, bus.mem_we_o}, {4'(S_MEM_REQ), 3'b111});
    nxt();
    bus.mem_gnt_i = 1'b0;
    #1;
    chk("sw_done", 32'(state), 32'(S_FETCH));

    // BEQ taken then not taken
    do_fetch(32'h00000063);
    nxt();
    br = 1'b1;
    #1;
    chk("beq_t", {state, pc_write, pc_src, src_a, src_b, alu_op},
        {4'(S_BRANCH), 1'b1, 2'b01, 6'b000001});
    nxt();
    br = 1'b0;
    #1;
    chk("beq_t_done", 32'(state), 32'(S_FETCH));
    do_fetch(32'h00000063);
    nxt();
    chk("beq_nt", {state, pc_write}, {4'(S_BRANCH), 1'b0});
    nxt();
    chk("beq_nt_done", 32'(state), 32'(S_FETCH));

    // Jumps
    do_fetch(32'h000080e7);
    nxt();
    chk("jalr", {state, reg_write, wb_sel, pc_write, pc_src, src_a, src_b, alu_op},
        {4'(S_JUMP), 1'b1, 2'b10, 1'b1, 2'b01, 6'b000100});
    nxt();
    chk("jalr_done", 32'(state), 32'(S_FETCH));
    do_fetch(32'h0000006f);
    nxt();
    chk("jal", {state, reg_write, wb_sel, pc_write, pc_src},
        {4'(S_JUMP), 1'b1, 2'b10, 1'b1, 2'b01});
    nxt();
    chk("jal_done", 32'(state), 32'(S_FETCH));

    // FENCE is a no-op straight back to FETCH
    do_fetch(32'h0000000f);
    nxt();
    chk("fence", 32'(state), 32'(S_FETCH));

    // Illegal opcode 0x7F
    do_fetch(32'h0000007f);
    nxt();
    chk("illegal_trap", {state, trap, pc_write, pc_src, cause, bus.mem_req_o},
        {4'(S_TRAP), 1'b1, 1'b1, 2'b10, 2'b01, 1'b0});
    nxt();
    chk("illegal_after", {state, trap, cause}, {4'(S_FETCH), 1'b0, 2'b01});

    // Fetch timeout: gnt never arrives, TRAP after 4 FETCH cycles
    for (int i = 0; i < 4; i++) begin
      chk("tmo_fetch", {state, bus.mem_req_o}, {4'(S_FETCH), 1'b1});
      nxt();
      #1;
    end
    chk("tmo_trap", {state, trap, pc_src, cause, bus.mem_req_o},
        {4'(S_TRAP), 1'b1, 2'b10, 2'b10, 1'b0});
    nxt();
    chk("tmo_after", {state, trap, cause}, {4'(S_FETCH), 1'b0, 2'b10});

    // Disabled timeout: still fetching after many idle cycles
    chk("notmo", {state0, bus0.mem_req_o, trap0, cause0}, {4'(S_FETCH), 1'b1, 1'b0, 2'b00});

    // Reset pulse during MEM_WAIT
    do_fetch(32'h00002083);
    nxt();
    nxt();
    bus.mem_gnt_i = 1'b1;
    nxt();
    bus.mem_gnt_i = 1'b0;
    #1;
    chk("rst_pre", 32'(state), 32'(S_MEM_WAIT));
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(outs), 32'd0);
    nxt();
    chk("rst_held", 32'(outs), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release", {state, bus.mem_req_o, bus.iord_o, cause}, {4'(S_FETCH), 2'b10, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle, FSM-based main controller for the RV32I core. It replaces the single-cycle opcode decoder with a sequencer that steps one instruction through fetch, decode, execute, memory and writeback over several cycles. It talks to a shared instruction/data memory port through a req/gnt/rvalid handshake and traps on illegal opcodes and bus timeouts. It sits between the instruction register / memory port and the datapath multiplexers, ALU and register file.

## Interface
- TIMEOUT_CYCLES, 16: cycles a wait state may last before a bus-timeout trap; 0 disables the timeout.
- ALU_OP_W, 2: width of alu_op_o.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- instr_i  in  32  current instruction register contents; opcode is instr_i[6:0].
- mem_gnt_i  in  1  memory accepted the request this cycle.
- mem_rvalid_i  in  1  read data valid this cycle.
- branch_taken_i  in  1  ALU comparison result for the current branch.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  write enable, qualified by mem_req_o.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_write_o  out  1  latch read data into the IR and the current PC into old_pc.
- pc_write_o  out  1  PC load enable.
- pc_src_o  out  2  00 PC+4, 01 ALU result/target, 10 trap vector.
- reg_write_o  out  1  register-file write enable.
- wb_sel_o  out  2  00 ALU, 01 memory data, 10 PC+4.
- alu_src_a_o  out  2  00 rs1, 01 old_pc, 10 zero.
- alu_src_b_o  out  2  00 rs2, 01 immediate, 10 constant 4.
- alu_op_o  out  ALU_OP_W  00 ADD, 01 compare (branch), 10 R-type funct decode, 11 I-type funct decode.
- trap_o  out  1  one-cycle trap pulse.
- trap_cause_o  out  2  00 none, 01 illegal opcode, 10 bus timeout; held until the next trap.
- state_o  out  4  current FSM state (debug).

## Operation
- Reset: all outputs are 0; state is FETCH; the timeout counter is 0; trap_cause_o is 00.
- Outputs are Moore (decoded from state) except the handshake-qualified pulses noted below.
- State transitions:
  - FETCH: mem_req_o=1, iord_o=0. On mem_gnt_i go to FETCH_WAIT.
  - FETCH_WAIT: on mem_rvalid_i, pulse ir_write_o and pc_write_o (pc_src=00), then go to DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (precompute old_pc+imm). Dispatch on opcode:
    - 0110011 and 0010011 → EXEC.
    - 0110111 (LUI) and 0010111 (AUIPC) → EXEC.
    - 0000011 (load) and 0100011 (store) → MEM_ADDR.
    - 1100011 (branch) → BRANCH.
    - 1101111 (JAL) and 1100111 (JALR) → JUMP.
    - 0001111 (FENCE) → FETCH, as a no-op.
    - Any other opcode → TRAP with cause 01.
  - EXEC: ALU operand selects per type. R-type: a=00, b=00, op=10. I-type: a=00, b=01, op=11. LUI: a=10, b=01, op=00. AUIPC: a=01, b=01, op=00. Next state ALU_WB.
  - ALU_WB: reg_write_o=1, wb_sel=00, then FETCH.
  - MEM_ADDR: a=00, b=01, op=00, then MEM_REQ.
  - MEM_REQ: mem_req_o=1, iord_o=1, mem_we_o=1 for stores. On mem_gnt_i a store goes to FETCH and a load goes to MEM_WAIT.
  - MEM_WAIT: on mem_rvalid_i go to MEM_WB.
  - MEM_WB: reg_write_o=1, wb_sel=01, then FETCH.
  - BRANCH: a=00, b=00, op=01. pc_write_o equals branch_taken_i, with pc_src=01 (the target latched in DECODE). Next state FETCH.
  - JUMP: reg_write_o=1, wb_sel=10, pc_write_o=1, pc_src=01. JALR recomputes the target: a=00, b=01, op=00. Next state FETCH.
  - TRAP: trap_o=1, pc_write_o=1, pc_src=10, then FETCH.
- Timeout:
  - The counter increments every cycle spent in FETCH, FETCH_WAIT, MEM_REQ or MEM_WAIT.
  - It clears on any state change.
  - When it reaches TIMEOUT_CYCLES-1 and the awaited event is absent that cycle, the next state is TRAP with cause 10.
  - If the event and the limit coincide, the event wins.
  - The counter saturates and never wraps.
  - mem_req_o drops on entry to TRAP; the memory must tolerate a withdrawn request.
- A gnt or rvalid in a state that does not expect it is ignored.

## Timing
- Latencies, fetch start to next FETCH, with zero-wait memory (gnt in the first request cycle, rvalid the following cycle):
  - ALU/LUI/AUIPC: 5 cycles.
  - Load: 7 cycles.
  - Store: 5 cycles.
  - Branch and jump: 4 cycles.
- ir_write_o and pc_write_o in FETCH_WAIT are single-cycle pulses coincident with mem_rvalid_i.
- An rst_ni assertion mid-instruction forces FETCH and zeroes outputs immediately, asynchronously. Any in-flight memory transaction is abandoned.

## Structure
- A shared package holds:
  - the state enum,
  - opcode localparams,
  - the encodings for pc_src, wb_sel, alu_src_a, alu_src_b, alu_op and trap_cause.
- One sub-module, mc_timeout_counter, is natural: parametrised by TIMEOUT_CYCLES, with clear/enable inputs and an expired output. It becomes a constant 0 when TIMEOUT_CYCLES=0.
- The FSM keeps separate next-state logic and output decode.

## Test plan
- ADDI (0x00500093) with zero-wait memory: reg_write_o high in cycle 5, wb_sel=00, return to FETCH in cycle 6.
- LW with gnt delayed 3 cycles and rvalid delayed 2 cycles: mem_req_o held until gnt, mem_we_o=0, reg_write_o with wb_sel=01 one cycle after rvalid.
- BEQ twice: with branch_taken_i=1, pc_write_o=1 and pc_src=01 in BRANCH; with branch_taken_i=0, pc_write_o stays 0.
- Opcode 0x7F: trap_o pulses one cycle after DECODE, trap_cause_o=01, pc_src=10.
- TIMEOUT_CYCLES=4 and mem_gnt_i never asserted in FETCH: TRAP entered after 4 FETCH cycles, trap_cause_o=10. With TIMEOUT_CYCLES=0 the controller waits indefinitely.
- rst_ni pulsed low during MEM_WAIT: outputs are 0 immediately and state_o=FETCH after release.
